// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 800x480@60 timing constants and delay-line payload type
package vga_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 88;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 32;
  localparam int MAX_TOTAL    = 2048;

  // Sync fields are "active" flags; panel polarity is applied at the output register.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vga_ctl_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - parameterised shift register with async active-low clear
module vga_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster counters, latency-matched sync/de and blanked RGB panel output
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE      = DEF_H_ACTIVE,
  parameter int H_FP          = DEF_H_FP,
  parameter int H_SYNC        = DEF_H_SYNC,
  parameter int H_BP          = DEF_H_BP,
  parameter int V_ACTIVE      = DEF_V_ACTIVE,
  parameter int V_FP          = DEF_V_FP,
  parameter int V_SYNC        = DEF_V_SYNC,
  parameter int V_BP          = DEF_V_BP,
  parameter bit H_SYNC_POL    = 1'b0,
  parameter bit V_SYNC_POL    = 1'b0,
  parameter int PIXEL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] pixel_in,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  output logic        frame_start,
  output logic [7:0]  frame_count,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  generate
    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_timing
      $error("vga_timing: H_TOTAL/V_TOTAL exceed the 11-bit counter range");
    end
  endgenerate

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  // 12-bit bounds so a region ending exactly at 2048 does not wrap to 0.
  localparam logic [11:0] H_ACT_E  = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_ACT_E  = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic     sync_q1;
  logic     run;
  vga_ctl_t raw_ctl;
  vga_ctl_t dly_ctl;
  logic [11:0] h_ext;
  logic [11:0] v_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      run     <= 1'b0;
    end else begin
      sync_q1 <= 1'b1;
      run     <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_h       <= '0;
      vga_v       <= '0;
      frame_count <= '0;
    end else if (run) begin
      if (vga_h == H_LAST) begin
        vga_h <= '0;
        if (vga_v == V_LAST) begin
          vga_v       <= '0;
          frame_count <= frame_count + 8'd1;
        end else begin
          vga_v <= vga_v + 11'd1;
        end
      end else begin
        vga_h <= vga_h + 11'd1;
      end
    end
  end

  assign frame_start = (vga_h == 11'd0) && (vga_v == 11'd0);

  assign h_ext = {1'b0, vga_h};
  assign v_ext = {1'b0, vga_v};

  // Held inactive until the synchroniser releases, so nothing leaks out while counters sit at (0,0).
  assign raw_ctl.hsync = run && (h_ext >= HS_START) && (h_ext < HS_END);
  assign raw_ctl.vsync = run && (v_ext >= VS_START) && (v_ext < VS_END);
  assign raw_ctl.de    = run && (h_ext < H_ACT_E) && (v_ext < V_ACT_E);

  vga_delay_line #(
    .WIDTH ($bits(vga_ctl_t)),
    .DEPTH (PIXEL_LATENCY)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (raw_ctl),
    .dout    (dly_ctl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync <= ~H_SYNC_POL;
      vsync <= ~V_SYNC_POL;
      de    <= 1'b0;
      rgb   <= '0;
    end else begin
      hsync <= dly_ctl.hsync ? H_SYNC_POL : ~H_SYNC_POL;
      vsync <= dly_ctl.vsync ? V_SYNC_POL : ~V_SYNC_POL;
      de    <= dly_ctl.de;
      rgb   <= dly_ctl.de ? pixel_in : 24'h0;
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - directed bench: default panel, shrunken frame, active-high zero-latency variant
module tb_vga_timing;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [23:0] p_def = '0, p_sm = '0, p_pol = '0;

  logic [10:0] d_h, d_v, s_h, s_v, q_h, q_v;
  logic        d_fs, d_hs, d_vs, d_de, s_fs, s_hs, s_vs, s_de, q_fs, q_hs, q_vs, q_de;
  logic [7:0]  d_fc, s_fc, q_fc;
  logic [23:0] d_rgb, s_rgb, q_rgb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_timing u_def (
    .clk(clk), .reset_n(reset_n), .pixel_in(p_def),
    .vga_h(d_h), .vga_v(d_v), .frame_start(d_fs), .frame_count(d_fc),
    .hsync(d_hs), .vsync(d_vs), .de(d_de), .rgb(d_rgb)
  );

  // 36 x 19 raster: H 20/4/5/7, V 10/2/3/4 -> 684 clocks per frame
  vga_timing #(
    .H_ACTIVE(20), .H_FP(4), .H_SYNC(5), .H_BP(7),
    .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(4)
  ) u_sm (
    .clk(clk), .reset_n(reset_n), .pixel_in(p_sm),
    .vga_h(s_h), .vga_v(s_v), .frame_start(s_fs), .frame_count(s_fc),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .rgb(s_rgb)
  );

  vga_timing #(
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIXEL_LATENCY(0)
  ) u_pol (
    .clk(clk), .reset_n(reset_n), .pixel_in(p_pol),
    .vga_h(q_h), .vga_v(q_v), .frame_start(q_fs), .frame_count(q_fc),
    .hsync(q_hs), .vsync(q_vs), .de(q_de), .rgb(q_rgb)
  );

  function automatic logic [23:0] pat(input int j, input int ht, input int vt);
    logic [10:0] hh, vv;
    if (j < 0) return 24'h0;
    hh = 11'(j % ht);
    vv = 11'((j / ht) % vt);
    return {hh[7:0], vv[7:0], 8'h5A};
  endfunction

  // Called at a negedge; returns at the negedge of cycle 0 (first cycle with the synchroniser released).
  task automatic release_reset();
    reset_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    reset_n = 1'b0;
    p_def = '0;
    p_sm  = '0;
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    p_def = 24'hFFFFFF; p_sm = 24'hFFFFFF; p_pol = 24'hFFFFFF;
    repeat (3) @(negedge clk);
    vectors++; if (d_rgb !== 24'h0) begin miscompares++; $display("FAIL reset_rgb: got %h expected 000000", d_rgb); end
    vectors++; if (d_de !== 1'b0) begin miscompares++; $display("FAIL reset_de: got %b expected 0", d_de); end
    vectors++; if (d_hs !== 1'b1 || d_vs !== 1'b1) begin miscompares++; $display("FAIL reset_sync: got h%b v%b expected h1 v1", d_hs, d_vs); end
    vectors++; if (d_h !== 11'd0 || d_v !== 11'd0 || d_fc !== 8'd0) begin miscompares++; $display("FAIL reset_counters: got h%0d v%0d f%0d expected 0 0 0", d_h, d_v, d_fc); end
    vectors++; if (q_hs !== 1'b0 || q_vs !== 1'b0) begin miscompares++; $display("FAIL reset_pol_sync: got h%b v%b expected h0 v0", q_hs, q_vs); end
    release_reset();
    vectors++; if (d_fs !== 1'b1) begin miscompares++; $display("FAIL frame_start_c0: got %b expected 1", d_fs); end
    @(negedge clk);
    vectors++; if (d_fs !== 1'b0) begin miscompares++; $display("FAIL frame_start_c1: got %b expected 0", d_fs); end
  endtask

  task automatic test_line_timing();
    int first_fall, second_fall, low_cnt, first_de, bad_stream, bad_cnt, bad_k, j, h, v;
    logic prev_hs, prev_de, e_de, e_hs;
    logic [23:0] e_rgb;
    first_fall = -1; second_fall = -1; low_cnt = 0; first_de = -1;
    bad_stream = 0; bad_cnt = 0; bad_k = -1; prev_hs = 1'b1; prev_de = 1'b0;
    restart();
    for (int k = 0; k < 1962; k++) begin
      j = k - 3;
      if (j < 0) begin
        e_de = 1'b0; e_hs = 1'b1; e_rgb = 24'h0;
      end else begin
        h = j % 976; v = j / 976;
        e_de  = (h < 800) && (v < 480);
        e_hs  = !((h >= 840) && (h < 888));
        e_rgb = e_de ? pat(j, 976, 528) : 24'h0;
      end
      if (d_de !== e_de || d_hs !== e_hs || d_vs !== 1'b1 || d_rgb !== e_rgb) begin
        bad_stream++;
        if (bad_k < 0) bad_k = k;
      end
      if (d_h !== 11'(k % 976) || d_v !== 11'(k / 976)) bad_cnt++;
      if (prev_hs && !d_hs) begin
        if (first_fall < 0) first_fall = k;
        else if (second_fall < 0) second_fall = k;
      end
      if (!d_hs && k < 1819) low_cnt++;
      if (!prev_de && d_de && first_de < 0) first_de = k;
      prev_hs = d_hs; prev_de = d_de;
      p_def = pat(k - 2, 976, 528);
      p_sm  = pat(k - 2, 36, 19);
      @(negedge clk);
    end
    vectors++; if (first_fall !== 843) begin miscompares++; $display("FAIL hsync_first_fall: got %0d expected 843", first_fall); end
    vectors++; if (second_fall - first_fall !== 976) begin miscompares++; $display("FAIL hsync_period: got %0d expected 976", second_fall - first_fall); end
    vectors++; if (low_cnt !== 48) begin miscompares++; $display("FAIL hsync_width: got %0d expected 48", low_cnt); end
    vectors++; if (first_de !== 3) begin miscompares++; $display("FAIL de_first_rise: got %0d expected 3", first_de); end
    vectors++; if (bad_stream !== 0) begin miscompares++; $display("FAIL line_stream: got %0d bad cycles (first at %0d) expected 0", bad_stream, bad_k); end
    vectors++; if (bad_cnt !== 0) begin miscompares++; $display("FAIL line_counters: got %0d bad cycles expected 0", bad_cnt); end
  endtask

  task automatic test_frame_timing();
    int fs_bad, vs_low, vs_fall, de_cnt, bad_stream, bad_k, j, h, v;
    logic prev_vs, e_de, e_hs, e_vs;
    logic [23:0] e_rgb;
    fs_bad = 0; vs_low = 0; vs_fall = -1; de_cnt = 0; bad_stream = 0; bad_k = -1; prev_vs = 1'b1;
    restart();
    for (int k = 0; k < 1371; k++) begin
      j = k - 3;
      if (j < 0) begin
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h0;
      end else begin
        h = j % 36; v = (j / 36) % 19;
        e_de  = (h < 20) && (v < 10);
        e_hs  = !((h >= 24) && (h < 29));
        e_vs  = !((v >= 12) && (v < 15));
        e_rgb = e_de ? pat(j, 36, 19) : 24'h0;
      end
      if (s_de !== e_de || s_hs !== e_hs || s_vs !== e_vs || s_rgb !== e_rgb) begin
        bad_stream++;
        if (bad_k < 0) bad_k = k;
      end
      if (s_fs !== ((k % 684) == 0)) fs_bad++;
      if (k < 684 && !s_vs) vs_low++;
      if (prev_vs && !s_vs && vs_fall < 0) vs_fall = k;
      if (k >= 3 && k < 687 && s_de) de_cnt++;
      prev_vs = s_vs;
      if (k == 683) begin
        vectors++; if (s_h !== 11'd35 || s_v !== 11'd18 || s_fc !== 8'd0) begin miscompares++; $display("FAIL pre_wrap: got h%0d v%0d f%0d expected 35 18 0", s_h, s_v, s_fc); end
      end
      if (k == 684) begin
        vectors++; if (s_h !== 11'd0 || s_v !== 11'd0 || s_fc !== 8'd1) begin miscompares++; $display("FAIL frame_wrap: got h%0d v%0d f%0d expected 0 0 1", s_h, s_v, s_fc); end
      end
      if (k == 1368) begin
        vectors++; if (s_fc !== 8'd2) begin miscompares++; $display("FAIL frame_count_2: got %0d expected 2", s_fc); end
      end
      p_def = pat(k - 2, 976, 528);
      p_sm  = pat(k - 2, 36, 19);
      @(negedge clk);
    end
    vectors++; if (fs_bad !== 0) begin miscompares++; $display("FAIL frame_start_pattern: got %0d bad cycles expected 0", fs_bad); end
    vectors++; if (vs_low !== 108) begin miscompares++; $display("FAIL vsync_width: got %0d expected 108", vs_low); end
    vectors++; if (vs_fall !== 435) begin miscompares++; $display("FAIL vsync_first_fall: got %0d expected 435", vs_fall); end
    vectors++; if (de_cnt !== 200) begin miscompares++; $display("FAIL de_per_frame: got %0d expected 200", de_cnt); end
    vectors++; if (bad_stream !== 0) begin miscompares++; $display("FAIL frame_stream: got %0d bad cycles (first at %0d) expected 0", bad_stream, bad_k); end
  endtask

  task automatic test_mid_reset();
    restart();
    for (int k = 0; k < 226; k++) begin
      p_sm = pat(k - 2, 36, 19);
      @(negedge clk);
    end
    vectors++; if (s_v !== 11'd6 || s_h !== 11'd10 || s_de !== 1'b1) begin miscompares++; $display("FAIL mid_pre: got h%0d v%0d de%b expected 10 6 1", s_h, s_v, s_de); end
    reset_n = 1'b0;
    #1;
    vectors++; if (s_de !== 1'b0 || s_rgb !== 24'h0) begin miscompares++; $display("FAIL mid_async_out: got de%b rgb %h expected de0 rgb 000000", s_de, s_rgb); end
    vectors++; if (s_hs !== 1'b1 || s_vs !== 1'b1) begin miscompares++; $display("FAIL mid_async_sync: got h%b v%b expected h1 v1", s_hs, s_vs); end
    vectors++; if (s_h !== 11'd0 || s_v !== 11'd0) begin miscompares++; $display("FAIL mid_async_cnt: got h%0d v%0d expected 0 0", s_h, s_v); end
    @(negedge clk);
    p_sm = 24'h0;
    release_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        vectors++; if (s_de !== 1'b0) begin miscompares++; $display("FAIL mid_de_c2: got %b expected 0", s_de); end
      end
      if (k == 3) begin
        vectors++; if (s_de !== 1'b1 || s_v !== 11'd0) begin miscompares++; $display("FAIL mid_de_c3: got de%b v%0d expected de1 v0", s_de, s_v); end
      end
      p_sm = pat(k - 1, 36, 19);
      @(negedge clk);
    end
  endtask

  task automatic test_polarity();
    int first_rise, high_cnt, first_de, bad;
    logic prev_hs, prev_de;
    first_rise = -1; high_cnt = 0; first_de = -1; bad = 0; prev_hs = 1'b0; prev_de = 1'b0;
    p_pol = 24'h123456;
    restart();
    for (int k = 0; k < 901; k++) begin
      if (!prev_hs && q_hs && first_rise < 0) first_rise = k;
      if (q_hs) high_cnt++;
      if (!prev_de && q_de && first_de < 0) first_de = k;
      if (q_vs !== 1'b0 || q_rgb !== (q_de ? 24'h123456 : 24'h0)) bad++;
      prev_hs = q_hs; prev_de = q_de;
      @(negedge clk);
    end
    vectors++; if (first_rise !== 841) begin miscompares++; $display("FAIL pol_hsync_rise: got %0d expected 841", first_rise); end
    vectors++; if (high_cnt !== 48) begin miscompares++; $display("FAIL pol_hsync_width: got %0d expected 48", high_cnt); end
    vectors++; if (first_de !== 1) begin miscompares++; $display("FAIL pol_de_rise: got %0d expected 1", first_de); end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL pol_stream: got %0d bad cycles expected 0", bad); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
    test_polarity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
